memory_arbiter: RTL
===================

# memory_arbiter

Shared-memory arbiter for the dual-core processor: sits directly downstream of each core's request unit and upstream of the single RAM port. It accepts per-core instruction fetch and data load/store requests (REN/WEN levels), serializes them onto the RAM and returns one-cycle `ihit`/`dhit` pulses with load data. The request units consume these pulses to drop or renew their enables.

## Interface
- `TIMEOUT`, default 15: max cycles in GRANT without `ramstate == ACCESS` before the transaction is aborted.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `iREN[1:0]`  in  2  per-core instruction read enable (level).
- `iaddr[1:0]`  in  2×word_t  per-core fetch address.
- `dREN[1:0]`, `dWEN[1:0]`  in  2 each  per-core data read/write enable; both high = write wins.
- `daddr[1:0]`, `dstore[1:0]`  in  2×word_t each  per-core data address / store data.
- `ihit[1:0]`, `dhit[1:0]`  out  2 each  one-cycle completion pulses.
- `iload[1:0]`, `dload[1:0]`  out  2×word_t each  returned data, valid while the matching hit is high.
- `ramREN`, `ramWEN`  out  1 each  RAM enables.
- `ramaddr`, `ramstore`  out  word_t each  RAM address / store data.
- `ramload`  in  word_t  RAM read data.
- `ramstate`  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.
- `err`  out  1  sticky: set on any timeout or ERROR abort; cleared only by reset.

## Operation
- FSM states: IDLE, GRANT, RESP.
- IDLE: if any request is pending, latch the winner (core id, type, addr, store data) and go to GRANT. Otherwise stay.
- Arbitration order: data requests before instruction requests. Within a class, the core selected by the round-robin pointer `rr` goes first.
- `rr` (reset 0) flips to the other core after every RESP.
- GRANT: drive `ramREN`/`ramWEN`, `ramaddr` and `ramstore` from the latched request, holding them constant.
  - `ramstate == ACCESS`: capture `ramload` into the response register, go to RESP.
  - `ramstate == ERROR`, or the wait counter reaches `TIMEOUT`: drop the RAM enables, set `err`, return to IDLE with no hit. The request is re-arbitrated.
- RESP: pulse exactly one of `ihit[c]`/`dhit[c]` for the granted core `c`; drive `iload[c]`/`dload[c]` from the response register. Go to IDLE.
- RESP does not re-sample requests. The request unit deasserts `dREN`/`dWEN` on the same edge, and the PC advances on `ihit`. IDLE therefore sees fresh requests.
- Writes return `dhit` with `dload` = 0.
- A requester whose enable drops while in GRANT: complete the transaction anyway. The hit pulse is ignored upstream.
- Wait counter: clog2(TIMEOUT+1) bits, cleared on entry to GRANT, saturating.

## Timing
- Reset values:
  - State IDLE, `rr` 0, `err` 0.
  - All hits 0, `ramREN`/`ramWEN` 0, `ramaddr`/`ramstore` 0.
  - Response register 0, all `iload`/`dload` 0.
- Minimum latency: request seen in IDLE at edge n → GRANT during cycle n+1 → with ACCESS in that same cycle, RESP (hit high) during cycle n+2. That is 2 cycles request-to-hit.
- Each RAM BUSY cycle adds one cycle.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, GRANT, RESP).
- All outputs are registered or decoded from the state register only. No combinational path from request inputs to RAM outputs or hits.
- Simultaneous requests from both cores in IDLE: arbitration order decides; the loser waits in IDLE for the next pass.
- Reset asserted mid-GRANT: RAM enables drop immediately (asynchronously). No hit is issued.

## Structure
- `ramstate_t`, `word_t` and `WORD_W` come from `cpu_types_pkg`.
- Add `arb_state_t` (IDLE/GRANT/RESP) to the same package.
- Natural sub-module: `rr_priority_sel`, a combinational picker that takes the four request bits and `rr` and returns the winner's core id and type.
- The FSM, latches and counter stay in `memory_arbiter`.

## Test plan
- Single fetch: core0 `iREN`, `iaddr` 0x40, RAM returns ACCESS on the first GRANT cycle with `ramload` 0xDEADBEEF. Required: `ihit[0]` exactly 2 cycles after the request, `iload[0]` 0xDEADBEEF.
- Data priority: core0 `iREN` and core1 `dWEN` (addr 0x80, store 0x1234) raised together. Required: the RAM write to 0x80 with 0x1234 happens first, `dhit[1]` before `ihit[0]`.
- Round-robin: both cores hold `dREN` continuously. Required: `dhit` alternates core0, core1, core0, core1.
- BUSY stretch: RAM reports BUSY for 3 cycles, then ACCESS. Required: RAM enables and address stable throughout, hit 3 cycles later than the minimum.
- Abort: RAM stays BUSY for `TIMEOUT` = 15 cycles. Required: enables drop, `err` = 1, no hit, and the same request re-granted next. Separately, an ERROR state gives the same response.
- Reset: assert `RST` during GRANT. Required: `ramREN`/`ramWEN` low with no clock edge, and after release state IDLE, `rr` 0, `err` 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the dual-core memory system: the machine word, the RAM
// port status reported by the memory model, and the arbiter FSM states.
// Ports: none (package only).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Status reported by the single RAM port.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // memory_arbiter FSM: one transaction walks IDLE -> GRANT -> RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles the per-core request/response signals and the RAM port that the
// arbiter sits between.
// Signals:
//   iREN/iaddr            per-core instruction fetch request
//   dREN/dWEN/daddr/dstore per-core data load/store request
//   ihit/dhit/iload/dload per-core completion pulses and returned data
//   ramREN/ramWEN/ramaddr/ramstore  RAM command
//   ramload/ramstate      RAM read data and status
//   err                   sticky abort flag
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (cores plus RAM)
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0] iREN;
  word_t [1:0] iaddr;
  logic [1:0] dREN;
  logic [1:0] dWEN;
  word_t [1:0] daddr;
  word_t [1:0] dstore;

  logic [1:0] ihit;
  logic [1:0] dhit;
  word_t [1:0] iload;
  word_t [1:0] dload;

  logic ramREN;
  logic ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  ramstate_t ramstate;

  logic err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/rr_priority_sel.sv
// rr_priority_sel
// Combinational winner picker for the arbiter. Any data request beats any
// instruction request; inside the winning class the core named by rr goes
// first, otherwise the other core.
// Ports:
//   ireq[1:0]  per-core instruction request
//   dreq[1:0]  per-core data request (read or write)
//   rr         round-robin pointer (preferred core)
//   valid      some request is pending
//   core       winning core id
//   is_data    winner is a data request
module rr_priority_sel (
  input  logic [1:0] ireq,
  input  logic [1:0] dreq,
  input  logic       rr,
  output logic       valid,
  output logic       core,
  output logic       is_data
);

  always_comb begin
    valid   = (|ireq) || (|dreq);
    is_data = |dreq;
    core    = rr;
    // Preferred core wins if it is asking in the chosen class, else the other.
    if (is_data) begin
      core = dreq[rr] ? rr : ~rr;
    end else begin
      core = ireq[rr] ? rr : ~rr;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Serialises instruction fetches and data loads/stores from two cores onto a
// single RAM port and returns one-cycle ihit/dhit pulses with the load data.
// Ports:
//   CLK   system clock, rising edge
//   RST   asynchronous active-high reset
//   bus   memory_arbiter_if.slave: core requests/responses, RAM port, err
// Parameter:
//   TIMEOUT  GRANT cycles tolerated without ACCESS before the request is
//            dropped and re-arbitrated
// All outputs are decoded from registers only, so no request input reaches
// the RAM command or the hit pulses combinationally.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  memory_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_t state;
  arb_state_t next_state;

  logic rr;
  logic err_q;

  logic lat_core;
  logic lat_data;
  logic lat_write;
  word_t lat_addr;
  word_t lat_store;
  word_t resp_q;

  logic [CNT_W-1:0] wait_cnt;

  logic [1:0] dreq;
  logic pick_valid;
  logic pick_core;
  logic pick_data;

  logic start;
  logic access;
  logic abort;

  assign dreq = bus.dREN | bus.dWEN;

  rr_priority_sel u_sel (
    .ireq    (bus.iREN),
    .dreq    (dreq),
    .rr      (rr),
    .valid   (pick_valid),
    .core    (pick_core),
    .is_data (pick_data)
  );

  // A transaction starts when IDLE sees any request; it completes on ACCESS
  // and is abandoned on an ERROR report or when the wait counter saturates.
  always_comb begin
    start  = (state == IDLE) && pick_valid;
    access = (state == GRANT) && (bus.ramstate == ACCESS);
    abort  = (state == GRANT) && (bus.ramstate != ACCESS) &&
             ((bus.ramstate == ERROR) || (wait_cnt == CNT_MAX));
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. RESP always returns to IDLE so fresh requests are
  // sampled only after the request units have reacted to the hit pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (access) begin
          next_state = RESP;
        end else if (abort) begin
          next_state = IDLE;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the winning request in IDLE and hold it for the whole GRANT so
  // the RAM command stays stable even if the requester drops its enable.
  // When both write and read are raised the write wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_core  <= 1'b0;
      lat_data  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_store <= '0;
    end else if (start) begin
      lat_core  <= pick_core;
      lat_data  <= pick_data;
      lat_write <= pick_data && bus.dWEN[pick_core];
      lat_addr  <= pick_data ? bus.daddr[pick_core] : bus.iaddr[pick_core];
      lat_store <= pick_data ? bus.dstore[pick_core] : '0;
    end
  end

  // GRANT wait counter: cleared when a transaction starts, counts every GRANT
  // cycle and saturates at TIMEOUT, which is also the abort point.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if ((state == GRANT) && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Response register: load data on a read ACCESS, zero for writes so that
  // a store completes with dload = 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_q <= '0;
    end else if (access) begin
      resp_q <= lat_write ? '0 : bus.ramload;
    end
  end

  // Round-robin pointer flips after every completed transaction; the sticky
  // error flag records any abort until the next reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == RESP) begin
        rr <= ~rr;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  // Output decode from the state register and latches. Because the RAM
  // enables depend on state, an asynchronous reset drops them immediately.
  always_comb begin
    bus.ramREN   = (state == GRANT) && !lat_write;
    bus.ramWEN   = (state == GRANT) && lat_write;
    bus.ramaddr  = (state == GRANT) ? lat_addr : '0;
    bus.ramstore = ((state == GRANT) && lat_write) ? lat_store : '0;

    bus.ihit  = '0;
    bus.dhit  = '0;
    bus.iload = '0;
    bus.dload = '0;
    if (state == RESP) begin
      if (lat_data) begin
        bus.dhit[lat_core]  = 1'b1;
        bus.dload[lat_core] = resp_q;
      end else begin
        bus.ihit[lat_core]  = 1'b1;
        bus.iload[lat_core] = resp_q;
      end
    end

    bus.err = err_q;
  end

endmodule
